// File: rtl/adc.sv
// adc: periodic 24-bit SPI ADC sampler emitting timestamped 3-beat AXI4-Stream packets.
// Optional ADC_SEQ_COUNTER_EN: tag byte carries an 8-bit packet sequence number instead of 0.
module adc #(
  parameter int TIMESTAMP_WIDTH = 64,
  parameter int C_M_AXIS_TDATA_WIDTH = 32,
  parameter int CONFIG_REG_DATA_WIDTH = 32,
  parameter int CONFIG_REG_ADDR_WIDTH = 3,
  parameter int SCLK_HALF_DIV = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic run,
  input  logic cfg_wr_en,
  input  logic [CONFIG_REG_ADDR_WIDTH-1:0] cfg_addr,
  input  logic [CONFIG_REG_DATA_WIDTH-1:0] cfg_wdata,
  output logic m_axis_tvalid,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic m_axis_tlast,
  input  logic m_axis_tready,
  output logic m_spi_clk,
  output logic m_spi_cs,
  input  logic m_spi_miso
);
  localparam int NB = TIMESTAMP_WIDTH / C_M_AXIS_TDATA_WIDTH;
  localparam int BW = $clog2(NB + 1);
  localparam int PW = $clog2(2 * SCLK_HALF_DIV + 1);
  localparam logic [PW-1:0] HL = PW'(SCLK_HALF_DIV - 1);
  localparam logic [PW-1:0] HH = PW'(2 * SCLK_HALF_DIV - 1);
  typedef enum logic [2:0] {IDLE, CS_SETUP, SHIFT, CS_HOLD, SEND} state_t;
  state_t state;
  logic enable;
  logic [CONFIG_REG_DATA_WIDTH-1:0] config_reg_samp_rate_div, div_cnt, eff_div;
  logic [TIMESTAMP_WIDTH-1:0] ts, ts_sh;
  logic [PW-1:0] ph;
  logic [4:0] bit_cnt;
  logic [23:0] sample;
  logic [BW-1:0] beat;
  logic [7:0] tag;
  logic go, trig;
  assign eff_div = (config_reg_samp_rate_div < CONFIG_REG_DATA_WIDTH'(2)) ? CONFIG_REG_DATA_WIDTH'(2) : config_reg_samp_rate_div;
  assign go = run && enable;
  assign trig = go && (div_cnt == eff_div - CONFIG_REG_DATA_WIDTH'(1));
`ifdef ADC_SEQ_COUNTER_EN
  logic [7:0] seq;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) seq <= '0;
    else if (m_axis_tvalid && m_axis_tready && m_axis_tlast) seq <= seq + 8'd1;
  assign tag = seq;
`else
  assign tag = 8'h00;
`endif
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      enable <= 1'b0;
      config_reg_samp_rate_div <= '0;
      ts <= '0;
      ts_sh <= '0;
      div_cnt <= '0;
      state <= IDLE;
      ph <= '0;
      bit_cnt <= '0;
      sample <= '0;
      beat <= '0;
      m_spi_cs <= 1'b1;
      m_spi_clk <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast <= 1'b0;
      m_axis_tdata <= '0;
    end else begin
      ts <= ts + 1'b1;
      div_cnt <= (!go || trig) ? '0 : div_cnt + 1'b1;
      if (cfg_wr_en && cfg_addr == CONFIG_REG_ADDR_WIDTH'(0)) enable <= cfg_wdata[0];
      if (cfg_wr_en && cfg_addr == CONFIG_REG_ADDR_WIDTH'(1)) config_reg_samp_rate_div <= cfg_wdata;
      case (state)
        IDLE: if (trig) begin
          ts_sh <= ts;
          m_spi_cs <= 1'b0;
          ph <= '0;
          state <= CS_SETUP;
        end
        CS_SETUP: begin
          ph <= (ph == HL) ? '0 : ph + 1'b1;
          if (ph == HL) begin
            bit_cnt <= '0;
            state <= SHIFT;
          end
        end
        // MISO is captured as SCLK rises; the ADC changes it on the falling edge
        SHIFT: begin
          ph <= (ph == HL) ? '0 : ph + 1'b1;
          if (ph == HL) begin
            m_spi_clk <= !m_spi_clk;
            if (!m_spi_clk) sample <= {sample[22:0], m_spi_miso};
            else begin
              bit_cnt <= bit_cnt + 5'd1;
              if (bit_cnt == 5'd23) state <= CS_HOLD;
            end
          end
        end
        CS_HOLD: begin
          ph <= (ph == HH) ? '0 : ph + 1'b1;
          if (ph == HL) m_spi_cs <= 1'b1;
          if (ph == HH) begin
            beat <= '0;
            state <= SEND;
            m_axis_tvalid <= 1'b1;
            m_axis_tdata <= ts_sh[C_M_AXIS_TDATA_WIDTH-1:0];
            ts_sh <= ts_sh >> C_M_AXIS_TDATA_WIDTH;
          end
        end
        SEND: if (m_axis_tready) begin
          beat <= beat + 1'b1;
          if (beat == BW'(NB)) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tlast <= 1'b0;
            state <= IDLE;
          end else if (beat == BW'(NB - 1)) begin
            m_axis_tdata <= {sample[15:0], sample[23:16], tag};
            m_axis_tlast <= 1'b1;
          end else begin
            m_axis_tdata <= ts_sh[C_M_AXIS_TDATA_WIDTH-1:0];
            ts_sh <= ts_sh >> C_M_AXIS_TDATA_WIDTH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_adc.sv
// tb_adc: scoreboard bench for adc; stimulus pushes expected beats, a negedge monitor pops and compares.
module tb_adc;
  logic clk = 0;
  logic resetn = 0;
  logic run = 0;
  logic cfg_wr_en = 0;
  logic [2:0] cfg_addr = '0;
  logic [31:0] cfg_wdata = '0;
  logic m_axis_tvalid;
  logic [31:0] m_axis_tdata;
  logic m_axis_tlast;
  logic m_axis_tready = 1;
  logic m_spi_clk;
  logic m_spi_cs;
  logic m_spi_miso = 0;

  adc dut (
    .clk(clk), .resetn(resetn), .run(run),
    .cfg_wr_en(cfg_wr_en), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
    .m_axis_tready(m_axis_tready),
    .m_spi_clk(m_spi_clk), .m_spi_cs(m_spi_cs), .m_spi_miso(m_spi_miso)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  longint cyc = 0;
  logic [32:0] sb[$];
  int pkts = 0;
  int cs_falls = 0;
  int sclk_n = 0;
  int beat_i = 0;
  logic loose = 0;
  logic [63:0] loose_first = '0;
  logic loose_have = 0;
  logic [63:0] loose_prev = '0;
  logic [31:0] lo_w = '0;
  logic [31:0] hi_w = '0;
  logic prev_sclk = 0;
  logic prev_cs = 1;
  logic prev_hold = 0;
  logic [31:0] prev_data = '0;
  logic prev_last = 0;
  logic [23:0] adc_val = 24'h001EAF;
  int idx = 23;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(posedge clk or negedge resetn)
    if (!resetn) cyc <= 0;
    else cyc <= cyc + 1;

  // ADC model: first bit appears with CS, later bits change on SCLK falling edges
  always @(negedge m_spi_cs) begin
    idx = 23;
    m_spi_miso = adc_val[idx];
  end
  always @(negedge m_spi_clk)
    if (m_spi_cs === 1'b0 && idx > 0) begin
      idx--;
      m_spi_miso = adc_val[idx];
    end

  always @(negedge clk) begin
    logic [32:0] e;
    logic [7:0] exp_tag;
    logic [63:0] t;
    if (resetn) begin
`ifdef ADC_SEQ_COUNTER_EN
      exp_tag = pkts[7:0];
`else
      exp_tag = 8'h00;
`endif
      if (!prev_sclk && m_spi_clk) sclk_n++;
      if (prev_cs && !m_spi_cs) begin
        cs_falls++;
        sclk_n = 0;
      end
      if (!prev_cs && m_spi_cs) chk("sclk_pulses", 64'(sclk_n), 64'd24);
      if (prev_hold) begin
        chk("hold_valid", 64'(m_axis_tvalid), 64'd1);
        chk("hold_data", 64'(m_axis_tdata), 64'(prev_data));
        chk("hold_last", 64'(m_axis_tlast), 64'(prev_last));
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (loose) begin
          if (beat_i == 0) begin
            lo_w = m_axis_tdata;
            chk("loose_last0", 64'(m_axis_tlast), 64'd0);
          end else if (beat_i == 1) begin
            hi_w = m_axis_tdata;
            chk("loose_last1", 64'(m_axis_tlast), 64'd0);
          end else begin
            chk("loose_sample", 64'(m_axis_tdata[31:8]), 64'h1EAF00);
            chk("loose_tag", 64'(m_axis_tdata[7:0]), 64'(exp_tag));
            chk("loose_last2", 64'(m_axis_tlast), 64'd1);
            t = {hi_w, lo_w};
            if (!loose_have) chk("loose_first_ts", t, loose_first);
            else chk("loose_period", 64'((((t - loose_prev) % 2) == 0) && ((t - loose_prev) >= 98)), 64'd1);
            loose_prev = t;
            loose_have = 1;
          end
        end else if (sb.size() == 0) begin
          checks++;
          $display("FAIL unexpected_beat: got %0h expected none", m_axis_tdata);
        end else begin
          e = sb.pop_front();
          if (e[32]) e[7:0] = exp_tag;
          chk("beat_data", 64'(m_axis_tdata), 64'(e[31:0]));
          chk("beat_last", 64'(m_axis_tlast), 64'(e[32]));
        end
        if (m_axis_tlast) begin
          pkts++;
          beat_i = 0;
        end else beat_i++;
      end
    end
    prev_sclk = m_spi_clk;
    prev_cs = m_spi_cs;
    prev_hold = resetn && m_axis_tvalid && !m_axis_tready;
    prev_data = m_axis_tdata;
    prev_last = m_axis_tlast;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cfg_wr(input logic [2:0] a, input logic [31:0] d);
    cfg_wr_en = 1;
    cfg_addr = a;
    cfg_wdata = d;
    tick(1);
    cfg_wr_en = 0;
  endtask

  task automatic push_pkt(input logic [63:0] ts);
    sb.push_back({1'b0, ts[31:0]});
    sb.push_back({1'b0, ts[63:32]});
    sb.push_back({1'b1, 16'h1EAF, 8'h00, 8'h00});
  endtask

  task automatic wait_pkts(input string name, input int n, input int budget);
    int c = 0;
    while (pkts < n && c < budget) begin
      tick(1);
      c++;
    end
    chk(name, 64'(pkts >= n), 64'd1);
  endtask

  initial begin
    longint k;
    int c;
    int f0;
    tick(1);
    for (int i = 0; i < 4; i++) begin
      chk("rst_cs", 64'(m_spi_cs), 64'd1);
      chk("rst_sclk", 64'(m_spi_clk), 64'd0);
      chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
      chk("rst_tlast", 64'(m_axis_tlast), 64'd0);
      chk("rst_tdata", 64'(m_axis_tdata), 64'd0);
      tick(1);
    end
    resetn = 1;
    for (int i = 0; i < 30; i++) begin
      chk("idle_cs", 64'(m_spi_cs), 64'd1);
      chk("idle_sclk", 64'(m_spi_clk), 64'd0);
      chk("idle_tvalid", 64'(m_axis_tvalid), 64'd0);
      tick(1);
    end
    chk("idle_no_cs", 64'(cs_falls), 64'd0);
    cfg_wr(3'd0, 32'd1);
    cfg_wr(3'd1, 32'd1000);
    cfg_wr(3'd5, 32'd7);
    tick(3);

    // three back-to-back packets at div=1000
    k = cyc;
    for (int n = 1; n <= 3; n++) push_pkt(64'(k + n * 1000 - 1));
    run = 1;
    wait_pkts("three_pkts", 3, 3500);
    run = 0;
    chk("three_pkts_cs", 64'(cs_falls), 64'd3);
    tick(10);

    // backpressure for 2000 clks after beat0; triggers during the stall are dropped
    k = cyc;
    push_pkt(64'(k + 999));
    push_pkt(64'(k + 3999));
    run = 1;
    c = 0;
    while (!m_axis_tvalid && c < 1200) begin
      tick(1);
      c++;
    end
    chk("bp_tvalid_seen", 64'(m_axis_tvalid), 64'd1);
    tick(1);
    m_axis_tready = 0;
    tick(2000);
    m_axis_tready = 1;
    wait_pkts("bp_pkts", 5, 1500);
    run = 0;
    chk("bp_cs_count", 64'(cs_falls), 64'd5);
    tick(10);

    // run dropped while shifting: capture still finishes
    k = cyc;
    push_pkt(64'(k + 999));
    run = 1;
    c = 0;
    while (m_spi_cs && c < 1200) begin
      tick(1);
      c++;
    end
    chk("shift_cs_low", 64'(m_spi_cs), 64'd0);
    tick(30);
    run = 0;
    wait_pkts("shift_pkt", 6, 500);
    f0 = cs_falls;
    tick(3000);
    chk("no_cs_after_stop", 64'(cs_falls), 64'(f0));
    chk("stop_tvalid", 64'(m_axis_tvalid), 64'd0);

    // div=1 clamps to 2: overlapping triggers dropped, no hang
    cfg_wr(3'd1, 32'd1);
    tick(2);
    loose = 1;
    loose_first = 64'(cyc + 1);
    run = 1;
    wait_pkts("div1_pkts", 10, 2000);
    run = 0;
    tick(300);
    chk("div1_idle_cs", 64'(m_spi_cs), 64'd1);
    chk("div1_idle_tvalid", 64'(m_axis_tvalid), 64'd0);
    loose = 0;
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
